// File: rtl/trigger_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// trigger_sequencer : multi-stage edge/level trigger with per-stage hit counts
// Revision 1.0
// ---------------------------------------------------------------------------
module trigger_sequencer #(
  parameter int SDW = 32,
  parameter int STN = 4,
  parameter int CNW = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STN*SDW-1:0] cfg_or,
  input  logic [STN*SDW-1:0] cfg_and,
  input  logic [STN*SDW-1:0] cfg_0_0,
  input  logic [STN*SDW-1:0] cfg_0_1,
  input  logic [STN*SDW-1:0] cfg_1_0,
  input  logic [STN*SDW-1:0] cfg_1_1,
  input  logic [STN*CNW-1:0] cfg_cnt,
  input  logic [STN-1:0]     cfg_cons,
  input  logic [3:0]         cfg_stn,
  input  logic               ctl_arm,
  input  logic               ctl_disarm,
  input  logic               sti_transfer,
  input  logic [SDW-1:0]     sti_tdata,
  output logic               sts_armed,
  output logic               sts_done,
  output logic               sts_evt,
  output logic [3:0]         sts_stage,
  output logic [CNW-1:0]     sts_cnt
);

  localparam logic [3:0] LAST_STAGE = 4'(STN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  logic [SDW-1:0] dly;

  // Tables are padded to 16 entries so the 4-bit stage index never overruns.
  logic [SDW-1:0] tab_or  [16];
  logic [SDW-1:0] tab_and [16];
  logic [SDW-1:0] tab_00  [16];
  logic [SDW-1:0] tab_01  [16];
  logic [SDW-1:0] tab_10  [16];
  logic [SDW-1:0] tab_11  [16];
  logic [CNW-1:0] tab_cnt [16];
  logic [15:0]    tab_cons;

  for (genvar s = 0; s < 16; s++) begin : g_stage
    if (s < STN) begin : g_used
      assign tab_or[s]   = cfg_or [s*SDW +: SDW];
      assign tab_and[s]  = cfg_and[s*SDW +: SDW];
      assign tab_00[s]   = cfg_0_0[s*SDW +: SDW];
      assign tab_01[s]   = cfg_0_1[s*SDW +: SDW];
      assign tab_10[s]   = cfg_1_0[s*SDW +: SDW];
      assign tab_11[s]   = cfg_1_1[s*SDW +: SDW];
      assign tab_cnt[s]  = cfg_cnt[s*CNW +: CNW];
      assign tab_cons[s] = cfg_cons[s];
    end else begin : g_unused
      assign tab_or[s]   = '0;
      assign tab_and[s]  = '0;
      assign tab_00[s]   = '0;
      assign tab_01[s]   = '0;
      assign tab_10[s]   = '0;
      assign tab_11[s]   = '0;
      assign tab_cnt[s]  = '0;
      assign tab_cons[s] = 1'b0;
    end
  end

  logic [SDW-1:0] match;
  logic [SDW-1:0] and_mask;
  logic           hit;
  logic [CNW-1:0] req;
  logic [CNW:0]   cnt_inc;
  logic [CNW-1:0] cnt_sat;
  logic           reached;
  logic [3:0]     stn_eff;

  always_comb begin
    and_mask = tab_and[sts_stage];
    match    = (~dly & ~sti_tdata & tab_00[sts_stage])
             | (~dly &  sti_tdata & tab_01[sts_stage])
             | ( dly & ~sti_tdata & tab_10[sts_stage])
             | ( dly &  sti_tdata & tab_11[sts_stage]);
    hit      = ((&(match | ~and_mask)) && (|and_mask))
             || (|(match & tab_or[sts_stage]));
    // A programmed count of zero behaves as a single required hit.
    req      = (tab_cnt[sts_stage] == '0) ? CNW'(1) : tab_cnt[sts_stage];
    cnt_inc  = {1'b0, sts_cnt} + (CNW+1)'(1);
    cnt_sat  = (&sts_cnt) ? sts_cnt : cnt_inc[CNW-1:0];
    reached  = (cnt_inc >= {1'b0, req});
    stn_eff  = (cfg_stn > LAST_STAGE) ? LAST_STAGE : cfg_stn;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dly       <= '0;
      sts_evt   <= 1'b0;
      sts_armed <= 1'b0;
      sts_done  <= 1'b0;
      sts_stage <= '0;
      sts_cnt   <= '0;
    end else begin
      sts_evt <= 1'b0;
      if (sti_transfer) begin
        dly <= sti_tdata;
      end
      if (ctl_arm) begin
        state     <= RUN;
        sts_armed <= 1'b1;
        sts_done  <= 1'b0;
        sts_stage <= '0;
        sts_cnt   <= '0;
      end else if (ctl_disarm) begin
        state     <= IDLE;
        sts_armed <= 1'b0;
        sts_done  <= 1'b0;
        sts_stage <= '0;
        sts_cnt   <= '0;
      end else if (state == RUN && sti_transfer) begin
        if (hit) begin
          if (reached) begin
            sts_cnt <= '0;
            if (sts_stage >= stn_eff) begin
              state     <= DONE;
              sts_armed <= 1'b0;
              sts_done  <= 1'b1;
              sts_evt   <= 1'b1;
            end else begin
              sts_stage <= sts_stage + 4'd1;
            end
          end else begin
            sts_cnt <= cnt_sat;
          end
        end else if (tab_cons[sts_stage]) begin
          sts_cnt <= '0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_trigger_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_trigger_sequencer : directed self-checking bench for trigger_sequencer
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_trigger_sequencer;
  localparam int SDW = 8;
  localparam int STN = 4;
  localparam int CNW = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [STN*SDW-1:0] cfg_or  = '0;
  logic [STN*SDW-1:0] cfg_and = '0;
  logic [STN*SDW-1:0] cfg_0_0 = '0;
  logic [STN*SDW-1:0] cfg_0_1 = '0;
  logic [STN*SDW-1:0] cfg_1_0 = '0;
  logic [STN*SDW-1:0] cfg_1_1 = '0;
  logic [STN*CNW-1:0] cfg_cnt = '0;
  logic [STN-1:0]     cfg_cons = '0;
  logic [3:0]         cfg_stn = '0;
  logic               ctl_arm = 1'b0;
  logic               ctl_disarm = 1'b0;
  logic               sti_transfer = 1'b0;
  logic [SDW-1:0]     sti_tdata = '0;
  logic               sts_armed;
  logic               sts_done;
  logic               sts_evt;
  logic [3:0]         sts_stage;
  logic [CNW-1:0]     sts_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trigger_sequencer #(.SDW(SDW), .STN(STN), .CNW(CNW)) dut (
    .clk(clk), .rst(rst),
    .cfg_or(cfg_or), .cfg_and(cfg_and),
    .cfg_0_0(cfg_0_0), .cfg_0_1(cfg_0_1), .cfg_1_0(cfg_1_0), .cfg_1_1(cfg_1_1),
    .cfg_cnt(cfg_cnt), .cfg_cons(cfg_cons), .cfg_stn(cfg_stn),
    .ctl_arm(ctl_arm), .ctl_disarm(ctl_disarm),
    .sti_transfer(sti_transfer), .sti_tdata(sti_tdata),
    .sts_armed(sts_armed), .sts_done(sts_done), .sts_evt(sts_evt),
    .sts_stage(sts_stage), .sts_cnt(sts_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic armed, input logic done,
                         input logic evt, input logic [3:0] stage, input logic [CNW-1:0] cnt);
    chk({tag, ".armed"}, 32'(sts_armed), 32'(armed));
    chk({tag, ".done"},  32'(sts_done),  32'(done));
    chk({tag, ".evt"},   32'(sts_evt),   32'(evt));
    chk({tag, ".stage"}, 32'(sts_stage), 32'(stage));
    chk({tag, ".cnt"},   32'(sts_cnt),   32'(cnt));
  endtask

  task automatic clear_cfg();
    cfg_or = '0; cfg_and = '0; cfg_0_0 = '0; cfg_0_1 = '0;
    cfg_1_0 = '0; cfg_1_1 = '0; cfg_cnt = '0; cfg_cons = '0; cfg_stn = '0;
  endtask

  task automatic set_stage(input int s, input logic [7:0] o, input logic [7:0] a,
                           input logic [7:0] m00, input logic [7:0] m01,
                           input logic [7:0] m10, input logic [7:0] m11,
                           input logic [7:0] c, input logic cons);
    cfg_or [s*SDW +: SDW] = o;
    cfg_and[s*SDW +: SDW] = a;
    cfg_0_0[s*SDW +: SDW] = m00;
    cfg_0_1[s*SDW +: SDW] = m01;
    cfg_1_0[s*SDW +: SDW] = m10;
    cfg_1_1[s*SDW +: SDW] = m11;
    cfg_cnt[s*CNW +: CNW] = c;
    cfg_cons[s]           = cons;
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic step(input logic arm, input logic disarm, input logic xfer, input logic [7:0] data);
    @(negedge clk);
    ctl_arm = arm; ctl_disarm = disarm; sti_transfer = xfer; sti_tdata = data;
    @(posedge clk);
    #1;
    ctl_arm = 1'b0; ctl_disarm = 1'b0; sti_transfer = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] data);
    step(1'b0, 1'b0, 1'b1, data);
  endtask

  initial begin
    // Reset state
    #12;
    chk_all("reset", 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    @(negedge clk) rst = 1'b0;

    // Single stage rising bit0
    clear_cfg();
    set_stage(0, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'd1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk_all("single.arm", 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    xfer(8'h01);
    chk_all("single.hit", 1'b0, 1'b1, 1'b1, 4'd0, 8'd0);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("single.evt_drop", 32'(sts_evt), 32'd0);
    chk("single.done_hold", 32'(sts_done), 32'd1);

    // Two stages: stage0 AND on 0xA5 x3, stage1 rising bit4
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk_all("two.disarm", 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    clear_cfg();
    set_stage(0, 8'h00, 8'hFF, 8'h5A, 8'h00, 8'h00, 8'hA5, 8'd3, 1'b0);
    set_stage(1, 8'h10, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'd1, 1'b0);
    cfg_stn = 4'd1;
    xfer(8'hA5);
    chk_all("two.idle_xfer", 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    xfer(8'hA5);
    chk("two.cnt1", 32'(sts_cnt), 32'd1);
    xfer(8'hA5);
    chk("two.cnt2", 32'(sts_cnt), 32'd2);
    xfer(8'hA5);
    chk_all("two.adv", 1'b1, 1'b0, 1'b0, 4'd1, 8'd0);
    xfer(8'hB5);
    chk_all("two.evt", 1'b0, 1'b1, 1'b1, 4'd1, 8'd0);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    xfer(8'hA5);
    chk("two.short_miss", 32'(sts_cnt), 32'd0);
    xfer(8'hA5);
    xfer(8'hB5);
    chk_all("two.short", 1'b1, 1'b0, 1'b0, 4'd0, 8'd1);

    // Consecutive-hit requirement
    clear_cfg();
    set_stage(0, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'd3, 1'b1);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    xfer(8'h01); chk("cons.c1", 32'(sts_cnt), 32'd1);
    xfer(8'h01); chk("cons.c2", 32'(sts_cnt), 32'd2);
    xfer(8'h00); chk("cons.c0", 32'(sts_cnt), 32'd0);
    xfer(8'h01); chk("cons.c1b", 32'(sts_cnt), 32'd1);
    xfer(8'h01);
    chk_all("cons.end", 1'b1, 1'b0, 1'b0, 4'd0, 8'd2);
    set_stage(0, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'd3, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("ncons.rearm", 32'(sts_cnt), 32'd0);
    xfer(8'h01); xfer(8'h01); xfer(8'h00);
    chk("ncons.hold", 32'(sts_cnt), 32'd2);
    xfer(8'h01);
    chk_all("ncons.evt", 1'b0, 1'b1, 1'b1, 4'd0, 8'd0);

    // Control precedence
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b1, 8'h01);
    chk_all("arm_hit", 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("disarm", 32'(sts_armed), 32'd0);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    chk("arm_disarm", 32'(sts_armed), 32'd1);

    // Four stages with out-of-range last-stage index, then async reset
    clear_cfg();
    for (int s = 0; s < STN; s++)
      set_stage(s, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'd1, 1'b0);
    cfg_stn = 4'hF;
    step(1'b1, 1'b0, 1'b0, 8'h00);
    xfer(8'h01); xfer(8'h01); xfer(8'h01);
    chk_all("clamp.s3", 1'b1, 1'b0, 1'b0, 4'd3, 8'd0);
    xfer(8'h01);
    chk_all("clamp.evt", 1'b0, 1'b1, 1'b1, 4'd3, 8'd0);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    xfer(8'h01); xfer(8'h01);
    chk("rst.pre", 32'(sts_stage), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk_all("rst.async", 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      xfer(8'h01);
      chk("rst.noevt", 32'(sts_evt), 32'd0);
    end
    chk_all("rst.after", 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);

    // Transfer low: data ignored and previous sample kept
    clear_cfg();
    set_stage(0, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'd1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    xfer(8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h01);
    chk_all("noxfer", 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    xfer(8'h01);
    chk_all("noxfer.dly", 1'b0, 1'b1, 1'b1, 4'd0, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/trigger_sequencer.md
TRIGGER_SEQUENCER -- requirements
Module: trigger_sequencer

Interface
REQ-001 SHALL have parameter SDW, default 32, sample data width in bits.
REQ-002 SHALL have parameter STN, default 4, number of sequencer stages (range 1..16).
REQ-003 SHALL have parameter CNW, default 16, occurrence counter width in bits.
REQ-004 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports cfg_or, cfg_and, cfg_0_0, cfg_0_1, cfg_1_0, cfg_1_1  input  STN*SDW each  per-stage match masks; stage s occupies bits [s*SDW +: SDW].
REQ-007 SHALL have port cfg_cnt  input  STN*CNW  per-stage required hit count; stage s occupies bits [s*CNW +: CNW].
REQ-008 SHALL have port cfg_cons  input  STN  per-stage flag: hits must be consecutive transfers.
REQ-009 SHALL have port cfg_stn  input  4  index of the last active stage (0..STN-1).
REQ-010 SHALL have ports ctl_arm, ctl_disarm  input  1 each  single-cycle control pulses.
REQ-011 SHALL have port sti_transfer  input  1  qualifies sti_tdata as a valid sample.
REQ-012 SHALL have port sti_tdata  input  SDW  sample data.
REQ-013 SHALL have ports sts_armed (1), sts_done (1), sts_evt (1), sts_stage (4), sts_cnt (CNW)  outputs  status, all registered.

Function
REQ-014 SHALL hold a previous-sample register dly, loaded with sti_tdata on each sti_transfer regardless of state.
REQ-015 SHALL compute per-bit match for stage s as OR of the four (previous,current) combinations (00,01,10,11) each ANDed with the corresponding cfg_x_y mask of stage s.
REQ-016 SHALL define hit(s) = (AND over bits of (match | ~cfg_and[s]) AND cfg_and[s] nonzero) OR (any bit of match & cfg_or[s]); hit(s) is combinational from current sti_tdata and dly.
REQ-017 SHALL implement states IDLE, RUN, DONE; sts_armed=1 only in RUN, sts_done=1 only in DONE.
REQ-018 SHALL, on ctl_arm in any state, enter RUN with sts_stage=0, sts_cnt=0; dly is not altered.
REQ-019 SHALL, on ctl_disarm without ctl_arm, enter IDLE and clear sts_stage and sts_cnt; ctl_arm wins if both asserted.
REQ-020 SHALL ignore hits in the cycle of ctl_arm or ctl_disarm.
REQ-021 SHALL, in RUN on sti_transfer with hit(sts_stage), increment sts_cnt; a required count of 0 is treated as 1.
REQ-022 SHALL, in RUN on sti_transfer without hit and cfg_cons[sts_stage]=1, clear sts_cnt; without cfg_cons it holds.
REQ-023 SHALL, when the increment reaches the required count, clear sts_cnt and advance sts_stage by 1, or if sts_stage >= cfg_stn enter DONE instead.
REQ-024 SHALL pulse sts_evt high for exactly one cycle, registered, on the edge that enters DONE (one cycle after the qualifying transfer is sampled).
REQ-025 SHALL evaluate only the current stage per transfer; one transfer advances at most one stage.
REQ-026 SHALL ignore sti_transfer in IDLE and DONE except for dly update; sts_cnt saturates at all-ones and never wraps.
REQ-027 SHALL treat cfg_stn > STN-1 as STN-1.

Reset
REQ-028 SHALL on rst force IDLE, dly=0, sts_evt=0, sts_armed=0, sts_done=0, sts_stage=0, sts_cnt=0, immediately and independent of clk.
REQ-029 SHALL, on rst assertion mid-sequence, abandon progress; re-arming is required after release.

Verification
REQ-030 Single stage, cfg_stn=0, cfg_0_1[0]=1, cfg_or[0]=1, cnt=1: arm, bit0 0->1 transfer -> sts_evt one cycle later, sts_done=1.
REQ-031 Two stages, stage0 AND on value 0xA5 (cfg_1_1|cfg_0_0 per bits, cfg_and=all), cnt=3, stage1 rising bit4: three 0xA5 transfers then bit4 rise -> sts_stage 0,1 then evt; fewer than 3 -> no evt.
REQ-032 cfg_cons=1, cnt=3: hit,hit,miss,hit,hit -> sts_cnt 1,2,0,1,2, no advance; cfg_cons=0 same stimulus -> advance on 3rd hit.
REQ-033 ctl_arm and hit in same cycle -> sts_cnt stays 0; ctl_arm and ctl_disarm together -> RUN.
REQ-034 rst asserted while sts_stage=2 -> all outputs 0 asynchronously; hits after release without arm -> no evt.
REQ-035 sti_transfer low with matching data -> no count change, dly unchanged.
